// File: rtl/systolic_input_feeder.sv
// systolic_input_feeder
// Transmit side of the systolic mesh data interface. Loads up to DEPTH
// north/west vector pairs, then on start replays them into the mesh boundary
// with a diagonal skew (lane k trails lane 0 by k cycles). Also produces the
// top-left valid, the last-element pulse and a stream-done pulse.
// Optional macro FEEDER_REPLAY_EN: when defined the buffer and count are kept
// after a stream so a further start replays it; when undefined the buffer is
// released (count cleared) after every stream.
module systolic_input_feeder #(
   parameter int N          = 2,
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 16
) (
   input  logic                         clk_i,
   input  logic                         rstn_i,
   input  logic                         in_valid_i,
   output logic                         in_ready_o,
   input  logic                         in_last_i,
   input  logic [0:N-1][DATA_WIDTH-1:0] north_vec_i,
   input  logic [0:N-1][DATA_WIDTH-1:0] west_vec_i,
   input  logic                         start_i,
   input  logic                         clear_i,
   output logic [0:N-1][DATA_WIDTH-1:0] north_o,
   output logic [0:N-1][DATA_WIDTH-1:0] west_o,
   output logic                         inputs_valid_o,
   output logic                         last_element_o,
   output logic                         busy_o,
   output logic                         stream_done_o,
   output logic [$clog2(DEPTH+1)-1:0]   count_o
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   // phase counts cycles since stream start and must reach L+N-1
   localparam int PW = $clog2(DEPTH + N + 1);

   localparam logic [1:0] FILL   = 2'd0;
   localparam logic [1:0] READY  = 2'd1;
   localparam logic [1:0] STREAM = 2'd2;
   localparam logic [1:0] DRAIN  = 2'd3;

   typedef logic [0:N-1][DATA_WIDTH-1:0] row_t;

   row_t          buf_north [0:DEPTH-1];
   row_t          buf_west  [0:DEPTH-1];

   logic [1:0]    state_reg;
   logic [CW-1:0] count_reg;
   logic [PW-1:0] phase_reg;
   row_t          row_north_reg;
   row_t          row_west_reg;
   logic          valid_reg;
   logic          done_reg;

   logic [PW-1:0] phase_next;
   logic [PW-1:0] len_ext;
   logic [AW-1:0] wr_idx;
   logic [AW-1:0] rd_idx;
   logic          busy;
   logic          accept;
   logic          more_rows;
   logic          at_end;

   assign busy       = (state_reg == STREAM) || (state_reg == DRAIN);
   assign in_ready_o = (state_reg == FILL) && (count_reg < CW'(DEPTH)) && !clear_i;
   assign accept     = in_valid_i && in_ready_o;
   assign len_ext    = PW'(count_reg);
   assign phase_next = phase_reg + PW'(1);
   // another buffered row remains to be fetched for the next cycle
   assign more_rows  = (phase_next < len_ext);
   // final busy cycle: the last lane is presenting element L-1
   assign at_end     = busy && (phase_next == len_ext + PW'(N - 1));
   assign wr_idx     = count_reg[AW-1:0];
   assign rd_idx     = (state_reg == READY) ? '0 : phase_next[AW-1:0];

   assign busy_o         = busy;
   assign last_element_o = at_end;
   assign inputs_valid_o = valid_reg;
   assign stream_done_o  = done_reg;
   assign count_o        = count_reg;

   // Stream buffer: written at the current fill index on each handshake
   always_ff @(posedge clk_i) begin
      if (accept) begin
         buf_north[wr_idx] <= north_vec_i;
         buf_west[wr_idx]  <= west_vec_i;
      end
   end

   // Control FSM plus the lane-0 output row register
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_reg     <= FILL;
         count_reg     <= '0;
         phase_reg     <= '0;
         row_north_reg <= '0;
         row_west_reg  <= '0;
         valid_reg     <= 1'b0;
         done_reg      <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            FILL: begin
               if (clear_i) begin
                  count_reg <= '0;
               end else if (accept) begin
                  count_reg <= count_reg + CW'(1);
                  if (in_last_i || (count_reg == CW'(DEPTH - 1))) begin
                     state_reg <= READY;
                  end
               end
            end
            READY: begin
               if (clear_i) begin
                  count_reg <= '0;
                  state_reg <= FILL;
               end else if (start_i) begin
                  state_reg     <= STREAM;
                  phase_reg     <= '0;
                  row_north_reg <= buf_north[rd_idx];
                  row_west_reg  <= buf_west[rd_idx];
                  valid_reg     <= 1'b1;
               end
            end
            default: begin
               // STREAM and DRAIN: fetch remaining rows, then push zeros
               phase_reg <= phase_next;
               if (more_rows) begin
                  row_north_reg <= buf_north[rd_idx];
                  row_west_reg  <= buf_west[rd_idx];
                  valid_reg     <= 1'b1;
               end else begin
                  row_north_reg <= '0;
                  row_west_reg  <= '0;
                  valid_reg     <= 1'b0;
               end
               if (at_end) begin
                  done_reg <= 1'b1;
`ifdef FEEDER_REPLAY_EN
                  state_reg <= READY;
`else
                  state_reg <= FILL;
                  count_reg <= '0;
`endif
               end else if (!more_rows) begin
                  state_reg <= DRAIN;
               end
            end
         endcase
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_lane
         if (gi == 0) begin : g_direct
            assign north_o[gi] = row_north_reg[gi];
            assign west_o[gi]  = row_west_reg[gi];
         end else begin : g_delay
            logic [DATA_WIDTH-1:0] north_dly_reg [0:gi-1];
            logic [DATA_WIDTH-1:0] west_dly_reg  [0:gi-1];

            // Delay line giving lane gi its gi-cycle skew behind lane 0
            always_ff @(posedge clk_i or negedge rstn_i) begin
               if (!rstn_i) begin
                  for (int j = 0; j < gi; j++) begin
                     north_dly_reg[j] <= '0;
                     west_dly_reg[j]  <= '0;
                  end
               end else begin
                  north_dly_reg[0] <= row_north_reg[gi];
                  west_dly_reg[0]  <= row_west_reg[gi];
                  for (int j = 1; j < gi; j++) begin
                     north_dly_reg[j] <= north_dly_reg[j-1];
                     west_dly_reg[j]  <= west_dly_reg[j-1];
                  end
               end
            end

            assign north_o[gi] = north_dly_reg[gi-1];
            assign west_o[gi]  = west_dly_reg[gi-1];
         end
      end
   endgenerate

endmodule

// File: tb/tb_systolic_input_feeder.sv
// Testbench for systolic_input_feeder. Stimulus tasks drive loads/starts and
// update a behavioural model; each start pushes the full expected output
// sequence into a queue that a negedge monitor pops whenever the DUT is busy
// or pulses stream_done_o.
module tb_systolic_input_feeder;

   localparam int N     = 2;
   localparam int DW    = 32;
   localparam int DEPTH = 16;
   localparam int CW    = $clog2(DEPTH + 1);
   localparam int RW    = N * DW;

   typedef logic [0:N-1][DW-1:0] row_t;
   typedef struct {
      int   cyc;
      row_t n;
      row_t w;
      bit   v;
      bit   last;
      bit   done;
      bit   busy;
   } exp_t;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          in_valid_i = 1'b0;
   logic          in_ready_o;
   logic          in_last_i = 1'b0;
   row_t          north_vec_i = '0;
   row_t          west_vec_i = '0;
   logic          start_i = 1'b0;
   logic          clear_i = 1'b0;
   row_t          north_o;
   row_t          west_o;
   logic          inputs_valid_o;
   logic          last_element_o;
   logic          busy_o;
   logic          stream_done_o;
   logic [CW-1:0] count_o;

   systolic_input_feeder #(.N(N), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
      .clk_i          (clk),
      .rstn_i         (rstn),
      .in_valid_i     (in_valid_i),
      .in_ready_o     (in_ready_o),
      .in_last_i      (in_last_i),
      .north_vec_i    (north_vec_i),
      .west_vec_i     (west_vec_i),
      .start_i        (start_i),
      .clear_i        (clear_i),
      .north_o        (north_o),
      .west_o         (west_o),
      .inputs_valid_o (inputs_valid_o),
      .last_element_o (last_element_o),
      .busy_o         (busy_o),
      .stream_done_o  (stream_done_o),
      .count_o        (count_o)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t exp_q[$];

   // model: 0 = loading, 1 = loaded/ready, 2 = streaming
   row_t m_n [0:DEPTH-1];
   row_t m_w [0:DEPTH-1];
   int   m_count = 0;
   int   m_state = 0;
   int   m_end   = 0;

   function automatic void check(string name, logic [RW-1:0] act, logic [RW-1:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endfunction

   function automatic row_t rand_row();
      row_t r;
      for (int k = 0; k < N; k++) r[k] = $urandom;
      return r;
   endfunction

   // Expected boundary traffic for a stream started in cycle c
   task automatic push_stream(input int c);
      int len;
      len = m_count;
      $display("stream start cycle %0d length %0d", c, len);
      for (int tau = c + 1; tau <= c + len + N; tau++) begin
         exp_t e;
         e.cyc = tau;
         for (int k = 0; k < N; k++) begin
            int t;
            t = tau - c - 1 - k;
            e.n[k] = (t >= 0 && t < len) ? m_n[t][k] : '0;
            e.w[k] = (t >= 0 && t < len) ? m_w[t][k] : '0;
         end
         e.v    = (tau - c - 1) < len;
         e.last = (tau == c + len + N - 1);
         e.done = (tau == c + len + N);
         e.busy = (tau <= c + len + N - 1);
         exp_q.push_back(e);
      end
   endtask

   // One clock cycle of stimulus; called at posedge+1
   task automatic step(input bit v, input bit l, input row_t n, input row_t w,
                       input bit s, input bit cl);
      bit exp_rdy;
      int c_now;
      c_now = cyc;
      if (m_state == 2 && c_now >= m_end) begin
`ifdef FEEDER_REPLAY_EN
         m_state = 1;
`else
         m_state = 0;
         m_count = 0;
`endif
      end
      in_valid_i = v; in_last_i = l; north_vec_i = n; west_vec_i = w;
      start_i = s; clear_i = cl;
      #1;
      exp_rdy = (m_state == 0) && (m_count < DEPTH) && !cl;
      check("in_ready", RW'(in_ready_o), RW'(exp_rdy));
      check("count", RW'(count_o), RW'(m_count));
      @(posedge clk);
      case (m_state)
         0: begin
            if (cl) m_count = 0;
            else if (v && exp_rdy) begin
               m_n[m_count] = n;
               m_w[m_count] = w;
               m_count++;
               if (l || m_count == DEPTH) m_state = 1;
            end
         end
         1: begin
            if (cl) begin
               m_count = 0;
               m_state = 0;
            end else if (s) begin
               push_stream(c_now);
               m_state = 2;
               m_end = c_now + m_count + N;
            end
         end
         default: ;
      endcase
      #1;
   endtask

   task automatic idle();
      step(0, 0, '0, '0, 0, 0);
   endtask

   task automatic wait_done();
      for (int i = 0; i < 200 && m_state == 2; i++) idle();
      if (m_state == 2) check("stream_timeout", 1, 0);
      repeat (2) idle();
   endtask

   // Scoreboard monitor, sampled on the falling edge
   always @(negedge clk) begin
      if (rstn) begin
         if (busy_o || stream_done_o) begin
            if (exp_q.size() == 0) begin
               check("unexpected_output", RW'({busy_o, stream_done_o}), 0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("out_cycle", RW'(cyc), RW'(e.cyc));
               check("north_o", north_o, e.n);
               check("west_o", west_o, e.w);
               check("inputs_valid", RW'(inputs_valid_o), RW'(e.v));
               check("last_element", RW'(last_element_o), RW'(e.last));
               check("stream_done", RW'(stream_done_o), RW'(e.done));
               check("busy", RW'(busy_o), RW'(e.busy));
            end
         end else begin
            check("idle_zero", RW'((|north_o) || (|west_o) || inputs_valid_o || last_element_o), 0);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      row_t rn, rw;
      int   c0;

      // ---- reset state ----
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", RW'(in_ready_o), 1);
      check("rst_count", RW'(count_o), 0);
      check("rst_outputs", RW'({busy_o, stream_done_o, inputs_valid_o, last_element_o}), 0);
      check("rst_north", north_o, '0);
      rstn = 1'b1;

      // ---- directed L=3 stream, start in FILL and during STREAM ignored ----
      rn[0] = 1;  rn[1] = 2;  rw[0] = 7;  rw[1] = 8;
      step(1, 0, rn, rw, 1, 0);
      rn[0] = 3;  rn[1] = 4;  rw[0] = 9;  rw[1] = 10;
      step(1, 0, rn, rw, 0, 0);
      rn[0] = 5;  rn[1] = 6;  rw[0] = 11; rw[1] = 12;
      step(1, 1, rn, rw, 0, 0);
      step(0, 0, '0, '0, 1, 0);
      idle();
      step(0, 0, '0, '0, 1, 0);
      wait_done();
      step(0, 0, '0, '0, 0, 1);

      // ---- L=1: second start replays or is ignored depending on build ----
      step(1, 1, rand_row(), rand_row(), 0, 0);
      step(0, 0, '0, '0, 1, 0);
      wait_done();
      step(0, 0, '0, '0, 1, 0);
      wait_done();
      step(0, 0, '0, '0, 0, 1);

      // ---- full DEPTH load without last, extra vector refused ----
      for (int i = 0; i < DEPTH; i++) step(1, 0, rand_row(), rand_row(), 0, 0);
      step(1, 0, rand_row(), rand_row(), 0, 0);
      step(0, 0, '0, '0, 1, 0);
      wait_done();
      step(0, 0, '0, '0, 0, 1);

      // ---- clear and start together in READY ----
      step(1, 0, rand_row(), rand_row(), 0, 0);
      step(1, 1, rand_row(), rand_row(), 0, 0);
      step(0, 0, '0, '0, 1, 1);
      repeat (4) idle();

      // ---- clear in FILL blocks the handshake and zeroes count ----
      step(1, 0, rand_row(), rand_row(), 0, 0);
      step(1, 0, rand_row(), rand_row(), 0, 0);
      step(1, 0, rand_row(), rand_row(), 0, 1);
      step(1, 1, rand_row(), rand_row(), 0, 0);
      step(0, 0, '0, '0, 1, 0);
      wait_done();
      step(0, 0, '0, '0, 0, 1);

      // ---- randomized streams ----
      for (int it = 0; it < 8; it++) begin
         int len;
         len = $urandom_range(1, DEPTH);
         for (int i = 0; i < len; i++) begin
            repeat ($urandom_range(0, 2)) idle();
            step(1, i == len - 1, rand_row(), rand_row(), $urandom_range(0, 4) == 0, 0);
         end
         repeat ($urandom_range(0, 3)) idle();
         step(0, 0, '0, '0, 1, 0);
         repeat (2) step(0, 0, '0, '0, $urandom_range(0, 1) == 1, 0);
         wait_done();
`ifdef FEEDER_REPLAY_EN
         if (it % 2 == 1) begin
            step(0, 0, '0, '0, 1, 0);
            wait_done();
         end
`endif
         step(0, 0, '0, '0, 0, 1);
      end

      // ---- reset asserted in cycle c+2 of an L=3 stream ----
      step(1, 0, rand_row(), rand_row(), 0, 0);
      step(1, 0, rand_row(), rand_row(), 0, 0);
      step(1, 1, rand_row(), rand_row(), 0, 0);
      c0 = cyc;
      step(0, 0, '0, '0, 1, 0);
      idle();
      rstn = 1'b0;
      #1;
      check("midrst_cycle", RW'(cyc), RW'(c0 + 2));
      check("midrst_ctrl", RW'({busy_o, stream_done_o, inputs_valid_o, last_element_o}), 0);
      check("midrst_north", north_o, '0);
      check("midrst_west", west_o, '0);
      check("midrst_count", RW'(count_o), 0);
      exp_q.delete();
      m_state = 0;
      m_count = 0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rstn = 1'b1;
      check("midrst_in_ready", RW'(in_ready_o), 1);
      repeat (8) idle();

      // ---- drain scoreboard ----
      for (int i = 0; i < 50 && exp_q.size() != 0; i++) idle();
      check("queue_empty", RW'(exp_q.size()), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
